// File: rtl/dac_adc_model_pkg.sv
// dac_adc_model_pkg: shared state encoding, exposure counter width and Gray encoder
package dac_adc_model_pkg;
  localparam int EXP_CNT_W = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, EXPOSE = 2'd1, CONVERT = 2'd2, READ = 2'd3} state_e;
  function automatic logic [31:0] gray_enc(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/dac_adc_model_if.sv
// dac_adc_model_if: sensor-FSM side requests (master drives) and model status (slave drives)
interface dac_adc_model_if #(
  parameter int N_ROWS = 2,
  parameter int N_COLS = 2,
  parameter int DATA_W = 8
);
  import dac_adc_model_pkg::*;
  localparam int RW = N_ROWS > 1 ? $clog2(N_ROWS) : 1;
  logic expose;
  logic convert;
  logic [N_ROWS-1:0] readRow;
  logic anaReset;
  logic [DATA_W-1:0] code;
  logic convDone;
  logic [EXP_CNT_W-1:0] expCount;
  logic [N_COLS*DATA_W-1:0] sample;
  logic [RW-1:0] sampleRow;
  logic sampleValid;
  logic protoErr;
  modport master (
    output expose, convert, readRow, anaReset,
    input code, convDone, expCount, sample, sampleRow, sampleValid, protoErr
  );
  modport slave (
    input expose, convert, readRow, anaReset,
    output code, convDone, expCount, sample, sampleRow, sampleValid, protoErr
  );
endinterface

// File: rtl/dac_adc_bus_drv.sv
// dac_adc_bus_drv: one pixel row; drives val onto every column bus unless rel is set
module dac_adc_bus_drv #(
  parameter int N_COLS = 2,
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0]        val,
  input  logic                     rel,
  inout  wire  [N_COLS*DATA_W-1:0] bus
);
  assign bus = rel ? 'z : {N_COLS{val}};
endmodule

// File: rtl/dac_adc_model.sv
// dac_adc_model: exposure/ramp stimulus, ADC code bus drive and row readout capture
// ports: clk, reset_n (async low), io (request/status interface), anaBias1, anaRamp, pixData (row-major pixel buses)
module dac_adc_model
  import dac_adc_model_pkg::*;
#(
  parameter int N_ROWS = 2,
  parameter int N_COLS = 2,
  parameter int DATA_W = 8,
  parameter int GRAY   = 0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  dac_adc_model_if.slave                  io,
  inout  wire                             anaBias1,
  inout  wire                             anaRamp,
  inout  wire  [N_ROWS*N_COLS*DATA_W-1:0] pixData
);
  localparam int RW = N_ROWS > 1 ? $clog2(N_ROWS) : 1;
  localparam int ROW_W = N_COLS * DATA_W;
  localparam logic [DATA_W-1:0] MAX = '1;
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_EXPOSE = EXPOSE;
  localparam logic [1:0] S_CONVERT = CONVERT;
  localparam logic [1:0] S_READ = READ;
  logic [1:0] state, nxt;
  logic [RW-1:0] row, row_in;
  logic captured, bias, ramp, rd_any, one_hot, multi, own, cap;
  logic [DATA_W-1:0] code_q, code_nxt, enc;
  logic [EXP_CNT_W-1:0] exp_cnt;
  logic [ROW_W-1:0] row_data;
  assign rd_any = |io.readRow;
  assign one_hot = rd_any && ((io.readRow & (io.readRow - N_ROWS'(1))) == '0);
  // any second request, or a non-one-hot row select, freezes the FSM
  assign multi = (io.expose & io.convert) | ((io.expose | io.convert) & rd_any) | (rd_any & ~one_hot);
  assign own = state == S_EXPOSE ? io.expose :
               state == S_CONVERT ? io.convert :
               state == S_READ ? io.readRow[row] : 1'b0;
  assign nxt = multi ? state :
               state == S_IDLE ? (io.expose ? S_EXPOSE : io.convert ? S_CONVERT : rd_any ? S_READ : S_IDLE) :
               own ? state : S_IDLE;
  assign code_nxt = (state != S_CONVERT && nxt == S_CONVERT) ? '0 :
                    (state == S_CONVERT && nxt == S_CONVERT && code_q != MAX) ? code_q + 1'b1 : code_q;
  // capture on the second READ cycle only, and only once per entry
  assign cap = state == S_READ && nxt == S_READ && !captured;
  assign enc = GRAY != 0 ? DATA_W'(gray_enc(32'(code_q))) : code_q;
  assign io.code = code_q;
  assign io.expCount = exp_cnt;
  assign anaBias1 = bias;
  assign anaRamp = ramp;
  always_comb begin
    row_in = '0;
    row_data = '0;
    for (int i = 0; i < N_ROWS; i++) begin
      if (io.readRow[i]) row_in = RW'(i);
      if (row == RW'(i)) row_data = pixData[i*ROW_W +: ROW_W];
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      row <= '0;
      captured <= 1'b0;
      code_q <= '0;
      bias <= 1'b0;
      ramp <= 1'b0;
      exp_cnt <= '0;
      io.convDone <= 1'b0;
      io.sample <= '0;
      io.sampleRow <= '0;
      io.sampleValid <= 1'b0;
      io.protoErr <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && nxt == S_READ) row <= row_in;
      captured <= state == S_READ && (captured || cap);
      code_q <= code_nxt;
      io.convDone <= code_nxt == MAX && code_q != MAX;
      ramp <= (nxt == S_CONVERT && code_nxt != MAX) ? ~ramp : 1'b0;
      bias <= nxt == S_EXPOSE ? ~bias : 1'b0;
      exp_cnt <= io.anaReset ? '0 : (nxt == S_EXPOSE && exp_cnt != '1) ? exp_cnt + 1'b1 : exp_cnt;
      if (cap) begin
        io.sample <= row_data;
        io.sampleRow <= row;
      end
      io.sampleValid <= cap;
      io.protoErr <= io.protoErr | multi;
    end
  end
  for (genvar r = 0; r < N_ROWS; r++) begin : g_row
    dac_adc_bus_drv #(.N_COLS(N_COLS), .DATA_W(DATA_W)) u_drv (
      .val(enc),
      .rel(state == S_READ && row == RW'(r)),
      .bus(pixData[r*ROW_W +: ROW_W])
    );
  end
endmodule

// File: tb/tb_dac_adc_model.sv
// tb_dac_adc_model: directed/randomized self-checking bench against a behavioural model
module tb_dac_adc_model;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic stub_en = 1'b0;
  wire bias, ramp;
  wire [31:0] pix;
  int checks = 0;
  int failures = 0;
  dac_adc_model_if #(.N_ROWS(2), .N_COLS(2), .DATA_W(8)) io ();
  dac_adc_model #(.N_ROWS(2), .N_COLS(2), .DATA_W(8), .GRAY(1)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .io(io),
    .anaBias1(bias),
    .anaRamp(ramp),
    .pixData(pix)
  );
  // pixel stub for row 1: column 0 = A5, column 1 = 3C
  assign pix[31:16] = stub_en ? 16'h3CA5 : 'z;
  always #5 clk = ~clk;
  function automatic logic [7:0] g(input int b);
    logic [7:0] v;
    v = 8'(b);
    return v ^ (v >> 1);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask
  initial begin
    int n, toggles, pulses, valids, ec, len;
    logic prev;
    io.expose = 1'b0;
    io.convert = 1'b0;
    io.readRow = 2'b00;
    io.anaReset = 1'b0;
    repeat (2) tick();
    chk("rst_pix", 64'(pix), 64'h0);
    chk("rst_code", 64'(io.code), 64'h0);
    reset_n = 1'b1;
    tick();
    chk("idle_pix", 64'(pix), 64'h0);
    chk("idle_exp", 64'(io.expCount), 64'h0);
    chk("idle_sample", 64'(io.sample), 64'h0);
    chk("idle_row", 64'(io.sampleRow), 64'h0);
    chk("idle_valid", 64'(io.sampleValid), 64'h0);
    chk("idle_done", 64'(io.convDone), 64'h0);
    chk("idle_err", 64'(io.protoErr), 64'h0);
    chk("idle_bias", 64'(bias), 64'h0);
    chk("idle_ramp", 64'(ramp), 64'h0);
    n = int'($urandom_range(5, 20));
    toggles = 0;
    prev = bias;
    io.expose = 1'b1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (bias !== prev) toggles++;
      prev = bias;
      chk("exp_cnt_run", 64'(io.expCount), 64'(i));
    end
    io.expose = 1'b0;
    tick();
    chk("exp_toggles", 64'(toggles), 64'(n));
    chk("exp_cnt", 64'(io.expCount), 64'(n));
    chk("exp_bias_off", 64'(bias), 64'h0);
    io.expose = 1'b1;
    io.anaReset = 1'b1;
    tick();
    chk("exp_rst_prio", 64'(io.expCount), 64'h0);
    io.anaReset = 1'b0;
    repeat (65540) tick();
    chk("exp_sat", 64'(io.expCount), 64'hFFFF);
    io.expose = 1'b0;
    tick();
    io.anaReset = 1'b1;
    tick();
    io.anaReset = 1'b0;
    chk("exp_clear", 64'(io.expCount), 64'h0);
    io.convert = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 300; c++) begin
      tick();
      ec = c - 1 > 255 ? 255 : c - 1;
      chk("conv_code", 64'(io.code), 64'(ec));
      chk("conv_bus", 64'(pix), 64'({4{g(ec)}}));
      chk("conv_ramp", 64'(ramp), ec < 255 ? 64'(c % 2) : 64'h0);
      if (ec == 128) chk("conv_gray128", 64'(pix[7:0]), 64'hC0);
      if (io.convDone) begin
        pulses++;
        chk("conv_done_at", 64'(io.code), 64'd255);
      end
    end
    chk("conv_pulses", 64'(pulses), 64'd1);
    io.convert = 1'b0;
    tick();
    chk("conv_hold", 64'(io.code), 64'd255);
    chk("conv_ramp_off", 64'(ramp), 64'h0);
    io.readRow = 2'b10;
    valids = 0;
    tick();
    chk("rd_row0_driven", 64'(pix[15:0]), 64'h8080);
    chk("rd_valid_early", 64'(io.sampleValid), 64'h0);
    stub_en = 1'b1;
    tick();
    if (io.sampleValid) valids++;
    chk("rd_row1_stub", 64'(pix[31:16]), 64'h3CA5);
    chk("rd_sample", 64'(io.sample), 64'h3CA5);
    chk("rd_sample_row", 64'(io.sampleRow), 64'd1);
    tick();
    if (io.sampleValid) valids++;
    chk("rd_valid_count", 64'(valids), 64'd1);
    io.readRow = 2'b00;
    stub_en = 1'b0;
    tick();
    chk("rd_redrive", 64'(pix), 64'h80808080);
    io.readRow = 2'b01;
    tick();
    io.readRow = 2'b00;
    tick();
    chk("rd_short_valid", 64'(io.sampleValid), 64'h0);
    chk("rd_short_sample", 64'(io.sample), 64'h3CA5);
    chk("rd_short_row", 64'(io.sampleRow), 64'd1);
    chk("pre_err", 64'(io.protoErr), 64'h0);
    io.expose = 1'b1;
    io.convert = 1'b1;
    tick();
    chk("err_set", 64'(io.protoErr), 64'h1);
    chk("err_no_conv", 64'(io.code), 64'd255);
    chk("err_no_bias", 64'(bias), 64'h0);
    io.expose = 1'b0;
    io.convert = 1'b0;
    tick();
    chk("err_sticky", 64'(io.protoErr), 64'h1);
    io.readRow = 2'b11;
    tick();
    chk("err_rd_driven", 64'(pix), 64'h80808080);
    io.readRow = 2'b00;
    repeat (2) tick();
    chk("err_rd_valid", 64'(io.sampleValid), 64'h0);
    chk("err_sticky2", 64'(io.protoErr), 64'h1);
    io.convert = 1'b1;
    repeat (101) tick();
    chk("mid_code", 64'(io.code), 64'd100);
    #2;
    reset_n = 1'b0;
    io.convert = 1'b0;
    #1;
    chk("async_code", 64'(io.code), 64'h0);
    chk("async_pix", 64'(pix), 64'h0);
    chk("async_err", 64'(io.protoErr), 64'h0);
    chk("async_ramp", 64'(ramp), 64'h0);
    reset_n = 1'b1;
    tick();
    len = int'($urandom_range(2, 40));
    io.convert = 1'b1;
    repeat (len) tick();
    chk("restart_code", 64'(io.code), 64'(len - 1));
    chk("restart_bus", 64'(pix), 64'({4{g(len - 1)}}));
    io.convert = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dac_adc_model.md
# dac_adc_model

Parametrised behavioural DAC/ADC model for the pixel-array testbench. It generates the exposure bias stimulus and the conversion ramp, and drives a binary or Gray-coded ADC counter onto every pixel data bus. It also releases one row at a time for readout and captures that row's pixel-driven values into registered sample outputs. It sits between the sensor state machine (expose/convert/readRow) and the pixel array, and supports arbitrary row count, column count and code width.

## Interface
- N_ROWS, 2, number of pixel rows (one read strobe each)
- N_COLS, 2, pixels per row
- DATA_W, 8, ADC code / pixel bus width
- GRAY, 0, 1 = drive code Gray-encoded, 0 = binary
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- expose  input  1  exposure request (level)
- convert  input  1  conversion request (level)
- readRow  input  N_ROWS  one-hot row read request (level)
- anaReset  input  1  pixel reset request; passed through, also clears expCount
- anaBias1  inout  1  exposure stimulus, driven always
- anaRamp  inout  1  ramp stimulus, driven always
- pixData  inout  N_ROWS*N_COLS*DATA_W  pixel buses, row-major; pixel (r,c) at bits [(r*N_COLS+c)*DATA_W +: DATA_W]
- code  output  DATA_W  current binary counter value
- convDone  output  1  one-cycle pulse when the counter reaches 2^DATA_W-1
- expCount  output  16  exposure cycles since the last anaReset, saturating at 16'hFFFF
- sample  output  N_COLS*DATA_W  captured row data
- sampleRow  output  $clog2(N_ROWS) (min 1)  row index of the current sample
- sampleValid  output  1  one-cycle pulse per capture
- protoErr  output  1  sticky protocol-error flag

## Operation
- State machine states: IDLE, EXPOSE, CONVERT, READ. Request decode: any = expose|convert|(|readRow).
- Leaving IDLE:
  - IDLE→EXPOSE on expose alone.
  - IDLE→CONVERT on convert alone; clears code to 0 on entry.
  - IDLE→READ on exactly one readRow bit alone.
- Returning to IDLE: from any non-IDLE state when its request drops. A different request arriving in the same cycle is taken from IDLE on the next cycle.
- Protocol errors:
  - More than one request asserted, or readRow not one-hot: state is held (IDLE stays IDLE), protoErr is set.
  - protoErr is cleared only by reset.
- EXPOSE:
  - anaBias1 toggles every cycle (clk/2 stimulus).
  - expCount increments every cycle, saturating.
  - In all other states anaBias1 = 0.
- CONVERT:
  - code increments by 1 every cycle and holds at 2^DATA_W-1 (no wrap).
  - convDone pulses in the cycle code becomes max.
  - anaRamp toggles every cycle while code < max and is 0 otherwise and outside CONVERT.
- Bus drive:
  - Every pixel bus is driven with enc(code), where enc = binary or (code ^ code>>1) per GRAY.
  - Exception: in READ, the buses of the selected row are high-Z; the other rows stay driven.
- READ capture:
  - In the second cycle of READ, pixData of the selected row is registered into sample, sampleRow is set to the row index, and sampleValid pulses.
  - This happens once per READ entry. Bus X/Z bits are captured as-is.
- anaReset clears expCount to 0 and has priority over the increment.
- Reset values: state IDLE; code 0; expCount 0; anaBias1 0; anaRamp 0; convDone 0; sample 0; sampleRow 0; sampleValid 0; protoErr 0. All buses are driven with enc(0) = 0.

## Timing
- All state, counter and output registers update on posedge clk. Reset is asynchronous on assertion and takes effect immediately, mid-operation included.
- Entry latency: a request sampled at edge k changes state at edge k. Stimulus (toggle, increment, Z) is visible after edge k.
- Conversion: the counter reaches max after 2^DATA_W-1 CONVERT cycles. convDone fires at edge k+2^DATA_W-1 relative to the entry edge k.
- Readout: the bus goes Z after edge k. sample/sampleValid update at edge k+1, giving the pixel one cycle to drive. If readRow drops after one cycle, no capture occurs.
- Bus release and re-drive are combinational from the registered state only. There are no combinational paths from inputs to the buses.

## Structure
- Shared package: the state enum (IDLE/EXPOSE/CONVERT/READ), the gray-encode function, and the EXP_CNT_W = 16 constant.
- One natural sub-module, `dac_adc_bus_drv`: per-row tri-state driver taking enc(code) and a release bit. Instantiate it N_ROWS times in a generate loop.

## Test plan
- Reset then idle, defaults: all pixData = 0 driven, all outputs zero, protoErr 0.
- Exposure: expose high for 10 cycles → anaBias1 toggles 10 times and expCount = 10. Then anaReset for 1 cycle → expCount = 0.
- Conversion, DATA_W=8, GRAY=1: convert for 300 cycles → code 0..255 then holds, convDone pulses once at cycle 255, and buses show Gray(code), e.g. 8'hC0 at code 128. anaRamp stays 0 after max.
- Read with a pixel stub driving row 1 with 8'hA5/8'h3C, N_ROWS=2: readRow = 2'b10 for 3 cycles → row-1 bus Z, row 0 driven, sample = {3C,A5}, sampleRow = 1, and exactly one sampleValid pulse.
- Protocol error: expose and convert together, and separately readRow = 2'b11 → state stays IDLE, protoErr sets and remains set until reset_n.
- Reset mid-conversion at code 100 → code 0 and buses driven 0 immediately. A new convert restarts from 0.
